weight_credit_tracker: RTL and testbench

Per-channel weight store and credit counter for the weighted round-robin arbiter. It accepts a one-hot grant, loads the granted channel's programmed weight into a credit counter, and decrements that counter on each served beat. When credit is exhausted it pulses done, so the arbiter can advance to the next channel. It sits between the arbiter's grant logic and the datapath beat strobe.

---
 rtl/weight_rr_pkg.sv | 16 +
 rtl/weight_onehot_enc.sv | 27 ++
 rtl/weight_credit_tracker.sv | 103 ++++++++++
 tb/tb_weight_credit_tracker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/weight_rr_pkg.sv
// Shared types and constants for the weighted round-robin credit tracker and its arbiter.
package weight_rr_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    localparam int WEIGHT_RST = 1;

    // A single-channel build still needs a 1-bit index port.
    function automatic int idx_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/weight_onehot_enc.sv
// One-hot to index encoder: the highest set bit wins. The multi flag marks grants with more than one bit set.
module weight_onehot_enc
    import weight_rr_pkg::*;
#(
    parameter int CHANNELS = 8,
    localparam int IDX_W = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] onehot,
    output logic [IDX_W-1:0]    idx,
    output logic                any,
    output logic                multi
);

    // Scanning upward lets later (higher) set bits overwrite earlier ones.
    always_comb begin
        idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (onehot[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any   = |onehot;
    assign multi = |(onehot & (onehot - CHANNELS'(1)));

endmodule

// File: rtl/weight_credit_tracker.sv
// Per-channel weight table and credit counter for the WRR arbiter; pulses done when a grant's credit runs out.
// Define ONEHOT_CHECK_EN to build the registered multi-hot grant check that drives onehot_err.
module weight_credit_tracker
    import weight_rr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    localparam int IDX_W   = idx_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                grant_valid,
    input  logic [CHANNELS-1:0] grant_onehot,
    input  logic                beat,
    output logic                busy,
    output logic [WIDTH-1:0]    credit,
    output logic [IDX_W-1:0]    cur_idx,
    output logic [WIDTH-1:0]    cur_weight,
    output logic                done,
    output logic                onehot_err
);

    state_e               state;
    logic [WIDTH-1:0]     weight [CHANNELS];
    logic [IDX_W-1:0]     enc_idx;
    logic                 enc_any;
    logic                 enc_multi;
    logic                 grant_take;
    logic [WIDTH-1:0]     grant_weight;

    weight_onehot_enc #(
        .CHANNELS (CHANNELS)
    ) u_enc (
        .onehot (grant_onehot),
        .idx    (enc_idx),
        .any    (enc_any),
        .multi  (enc_multi)
    );

    assign grant_take   = (state == IDLE) && grant_valid && enc_any;
    assign grant_weight = weight[enc_idx];
    assign busy         = (state == SERVE);

    // Weight table: the grant path reads the pre-write value on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                weight[i] <= WIDTH'(WEIGHT_RST);
            end
        end else if (wr_en && (int'(wr_idx) < CHANNELS)) begin
            weight[wr_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            credit     <= '0;
            cur_idx    <= '0;
            cur_weight <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (grant_take) begin
                    cur_idx    <= enc_idx;
                    cur_weight <= grant_weight;
                    credit     <= grant_weight;
                    // A zero-weight channel is skipped immediately via done.
                    if (grant_weight != '0) begin
                        state <= SERVE;
                    end else begin
                        done <= 1'b1;
                    end
                end
            end else if (beat) begin
                credit <= credit - WIDTH'(1);
                if (credit == WIDTH'(1)) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
            end
        end
    end

`ifdef ONEHOT_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            onehot_err <= 1'b0;
        end else begin
            onehot_err <= grant_take && enc_multi;
        end
    end
`else
    logic unused_enc_multi;
    assign unused_enc_multi = enc_multi;
    assign onehot_err       = 1'b0;
`endif

endmodule

// File: tb/tb_weight_credit_tracker.sv
// Scoreboard bench for weight_credit_tracker: directed scenarios followed by randomized traffic against a reference model.
module tb_weight_credit_tracker;

    localparam int WIDTH    = 32;
    localparam int CHANNELS = 8;
    localparam int IDX_W    = 3;

    logic                clk;
    logic                reset;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [WIDTH-1:0]    wr_data;
    logic                grant_valid;
    logic [CHANNELS-1:0] grant_onehot;
    logic                beat;
    logic                busy;
    logic [WIDTH-1:0]    credit;
    logic [IDX_W-1:0]    cur_idx;
    logic [WIDTH-1:0]    cur_weight;
    logic                done;
    logic                onehot_err;

    typedef struct packed {
        logic             busy;
        logic [WIDTH-1:0] credit;
        logic [IDX_W-1:0] idx;
        logic [WIDTH-1:0] weight;
        logic             done;
        logic             err;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model state, kept as plain quantities rather than an FSM.
    bit [WIDTH-1:0] mw [CHANNELS];
    bit             m_serving;
    bit [WIDTH-1:0] m_credit;
    bit [IDX_W-1:0] m_idx;
    bit [WIDTH-1:0] m_weight;

    weight_credit_tracker #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .grant_valid  (grant_valid),
        .grant_onehot (grant_onehot),
        .beat         (beat),
        .busy         (busy),
        .credit       (credit),
        .cur_idx      (cur_idx),
        .cur_weight   (cur_weight),
        .done         (done),
        .onehot_err   (onehot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input bit rst_n, input bit we, input int widx, input bit [WIDTH-1:0] wd,
                                 input bit gv, input bit [CHANNELS-1:0] g, input bit bt);
        exp_t e;
        bit   pulse;
        bit   err;
        int   gi;
        @(negedge clk);
        reset        = rst_n;
        wr_en        = we;
        wr_idx       = IDX_W'(widx);
        wr_data      = wd;
        grant_valid  = gv;
        grant_onehot = g;
        beat         = bt;
        pulse = 1'b0;
        err   = 1'b0;
        if (!rst_n) begin
            foreach (mw[i]) mw[i] = 1;
            m_serving = 1'b0;
            m_credit  = '0;
            m_idx     = '0;
            m_weight  = '0;
        end else begin
            if (m_serving) begin
                if (bt) begin
                    m_credit = m_credit - 1;
                    if (m_credit == 0) begin
                        m_serving = 1'b0;
                        pulse     = 1'b1;
                    end
                end
            end else if (gv && g != 0) begin
                gi       = int'(g);
                m_idx    = IDX_W'($clog2(gi + 1) - 1);
                m_weight = mw[m_idx];
                m_credit = m_weight;
                if (m_weight == 0) pulse = 1'b1;
                else m_serving = 1'b1;
`ifdef ONEHOT_CHECK_EN
                err = ($countones(g) > 1);
`endif
            end
            if (we && widx < CHANNELS) mw[widx] = wd;
        end
        e.busy   = m_serving;
        e.credit = m_credit;
        e.idx    = m_idx;
        e.weight = m_weight;
        e.done   = pulse;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if (busy !== e.busy || credit !== e.credit || cur_idx !== e.idx ||
            cur_weight !== e.weight || done !== e.done || onehot_err !== e.err) begin
            mismatched++;
            $display("[TB] FAIL cycle_check #%0d: got busy=%0b credit=%0d idx=%0d weight=%0d done=%0b err=%0b, expected busy=%0b credit=%0d idx=%0d weight=%0d done=%0b err=%0b",
                     compared, busy, credit, cur_idx, cur_weight, done, onehot_err,
                     e.busy, e.credit, e.idx, e.weight, e.done, e.err);
        end
    endtask

    // Monitor: every cycle the DUT presents a registered result, compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, '0, 0, '0, 0);
    endtask

    task automatic grant(input bit [CHANNELS-1:0] g);
        applyStimulus(1, 0, 0, '0, 1, g, 0);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, '0, 0, '0, 1);
    endtask

    task automatic wr(input int idx, input bit [WIDTH-1:0] d);
        applyStimulus(1, 1, idx, d, 0, '0, 0);
    endtask

    initial begin
        bit             rr;
        bit             we;
        bit [WIDTH-1:0] wd;
        bit [CHANNELS-1:0] g;
        int             sel;
        reset = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        grant_valid = 1'b0; grant_onehot = '0; beat = 1'b0;

        applyStimulus(0, 0, 0, '0, 0, '0, 0);
        applyStimulus(0, 0, 0, '0, 0, '0, 0);
        idle(1);

        grant(8'b0000_0100);
        beats(1);
        idle(2);

        wr(5, 3);
        grant(8'b0010_0000);
        beats(3);
        idle(1);

        wr(1, 0);
        grant(8'b0000_0010);
        idle(2);

        grant(8'b0010_0000);
        beats(1);
        applyStimulus(1, 1, 5, 9, 1, 8'b0000_0001, 0);
        beats(2);
        grant(8'b0010_0000);
        beats(9);
        idle(1);

        grant(8'b1000_0010);
        beats(1);
        idle(1);

        wr(3, 4);
        grant(8'b0000_1000);
        beats(2);
        applyStimulus(0, 0, 0, '0, 0, '0, 0);
        idle(1);
        grant(8'b0000_1000);
        beats(1);
        applyStimulus(1, 1, 6, 32'hFFFF_FFFF, 0, '0, 0);
        grant(8'b0100_0000);
        beats(3);
        applyStimulus(0, 0, 0, '0, 0, '0, 0);

        for (int c = 0; c < 1500; c++) begin
            rr  = ($urandom_range(0, 99) != 0);
            we  = ($urandom_range(0, 3) == 0);
            wd  = ($urandom_range(0, 49) == 0) ? 32'hFFFF_FFFF : WIDTH'($urandom_range(0, 5));
            sel = $urandom_range(0, 3);
            if (sel == 0) g = '0;
            else if (sel == 1) g = CHANNELS'($urandom);
            else g = CHANNELS'(1) << $urandom_range(0, CHANNELS - 1);
            applyStimulus(rr, we, $urandom_range(0, CHANNELS - 1), wd,
                          $urandom_range(0, 1) == 1, g, $urandom_range(0, 3) != 0);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
